mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter_n.sv | 45 ++++
 rtl/mux_arb_n.sv | 85 ++++++++
 tb/tb_mux_arb_n.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel output-registered mux/arbiter.
// Mode encodings and the select-width derivation.
package mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  function automatic int sel_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin grant: rotating priority search starting after the
// last granted channel; pointer advances only when a grant is taken.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SELW = sel_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                take,
  output logic [SELW-1:0]     gnt_idx,
  output logic                gnt_vld
);

  localparam logic [SELW-1:0] PTR_RST = SELW'(CHANNELS - 1);

  logic [SELW-1:0] ptr;

  // First requester at or after ptr+1, wrapping; descending scan
  // so the nearest candidate is written last and wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % CHANNELS;
      if (req[idx]) begin
        gnt_idx = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  // Pointer remembers the last channel that actually transferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= PTR_RST;
    end else if (take) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel mux with registered output stage; channel picked by
// sel (SELECT) or by a round-robin arbiter (ROUND_ROBIN).
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SELW = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  assign load = !out_valid || out_ready;
  assign xfer = |(in_valid & in_ready);

  if (MODE == MODE_RR) begin : g_rr
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_arbiter_n #(
      .CHANNELS(CHANNELS)
    ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (in_valid),
      .take   (xfer),
      .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld)
    );
  end else begin : g_sel
    assign gnt_idx = sel;
    assign gnt_vld = int'(sel) < CHANNELS;
  end

  // One-hot ready on the granted channel, only when the slot can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && load && gnt_vld &&
                    (gnt_idx == SELW'(i));
    end
  end

  // Data word of the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: replace on load, clear valid when nothing arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gnt_data;
        out_chan <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: SELECT x4, SELECT x5 and ROUND_ROBIN x4
// instances against a transaction-level reference model.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s4_in_data;
  logic [3:0]  s4_in_valid, s4_in_ready;
  logic [1:0]  s4_sel, s4_out_chan;
  logic [7:0]  s4_out_data;
  logic        s4_out_valid, s4_out_ready;

  logic [39:0] s5_in_data;
  logic [4:0]  s5_in_valid, s5_in_ready;
  logic [2:0]  s5_sel, s5_out_chan;
  logic [7:0]  s5_out_data;
  logic        s5_out_valid, s5_out_ready;

  logic [31:0] r4_in_data;
  logic [3:0]  r4_in_valid, r4_in_ready;
  logic [1:0]  r4_sel, r4_out_chan;
  logic [7:0]  r4_out_data;
  logic        r4_out_valid, r4_out_ready;

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_data(s4_in_data),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .sel(s4_sel),
    .out_data(s4_out_data), .out_chan(s4_out_chan),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready));

  mux_arb_n #(.WIDTH(8), .CHANNELS(5), .MODE(0)) u_s5 (
    .clk(clk), .rst_n(rst_n), .in_data(s5_in_data),
    .in_valid(s5_in_valid), .in_ready(s5_in_ready), .sel(s5_sel),
    .out_data(s5_out_data), .out_chan(s5_out_chan),
    .out_valid(s5_out_valid), .out_ready(s5_out_ready));

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_data(r4_in_data),
    .in_valid(r4_in_valid), .in_ready(r4_in_ready), .sel(r4_sel),
    .out_data(r4_out_data), .out_chan(r4_out_chan),
    .out_valid(r4_out_valid), .out_ready(r4_out_ready));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: one output slot per DUT plus last-granted channel.
  logic       m_v [3];
  logic [7:0] m_d [3];
  int         m_c [3];
  int         m_p [3];

  function automatic int rr_pick(int p, logic [15:0] vld, int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (p + k) % n;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_rdy(int mode, int n, logic v,
      logic ordy, int s, int p, logic [15:0] vld);
    int g;
    if (!rst_n || (v && !ordy)) return 16'h0;
    if (mode == 0) g = (s < n) ? s : -1;
    else g = rr_pick(p, vld, n);
    return (g >= 0) ? (16'h1 << g) : 16'h0;
  endfunction

  function automatic void mstep(int id, int mode, int n,
      logic [15:0] vld, logic [127:0] dat, int s, logic ordy);
    int g;
    if (!rst_n) begin
      m_v[id] = 1'b0; m_d[id] = 8'h0; m_c[id] = 0; m_p[id] = n - 1;
      return;
    end
    if (m_v[id] && !ordy) return;
    if (mode == 0) g = (s < n) ? s : -1;
    else g = rr_pick(m_p[id], vld, n);
    if (g >= 0 && vld[g]) begin
      m_v[id] = 1'b1; m_d[id] = dat[g*8 +: 8]; m_c[id] = g;
      if (mode == 1) m_p[id] = g;
    end else begin
      m_v[id] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    mstep(0, 0, 4, {12'b0, s4_in_valid}, {96'b0, s4_in_data},
          int'(s4_sel), s4_out_ready);
    mstep(1, 0, 5, {11'b0, s5_in_valid}, {88'b0, s5_in_data},
          int'(s5_sel), s5_out_ready);
    mstep(2, 1, 4, {12'b0, r4_in_valid}, {96'b0, r4_in_data},
          0, r4_out_ready);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s4_in_valid = 4'hF; s5_in_valid = 5'h1F; r4_in_valid = 4'hF;
    s4_out_ready = 1'b1; s5_out_ready = 1'b1; r4_out_ready = 1'b1;
    #1;
    n_checks++;
    if ({s4_in_ready, s5_in_ready, r4_in_ready} !== 13'h0) begin
      n_fail++;
      $display("FAIL rst_ready got=%h want=0",
               {s4_in_ready, s5_in_ready, r4_in_ready});
    end
    tick();
    n_checks++;
    if ({s4_out_valid, s5_out_valid, r4_out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_valid got=%b want=000",
               {s4_out_valid, s5_out_valid, r4_out_valid});
    end
    n_checks++;
    if ({s4_out_data, s4_out_chan, r4_out_data, r4_out_chan} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_data got=%h want=0",
               {s4_out_data, s4_out_chan, r4_out_data, r4_out_chan});
    end
    s4_in_valid = '0; s5_in_valid = '0; r4_in_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_sel_basic();
    s4_sel = 2'd2; s4_in_data = 32'h00A5_0000;
    s4_in_valid = 4'b0100; s4_out_ready = 1'b1;
    #1;
    n_checks++;
    if (s4_in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sel_ready got=%b want=0100", s4_in_ready);
    end
    tick();
    n_checks++;
    if ({s4_out_valid, s4_out_chan, s4_out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      n_fail++;
      $display("FAIL sel_out got=%b/%0d/%h want=1/2/a5",
               s4_out_valid, s4_out_chan, s4_out_data);
    end
  endtask

  task automatic test_sel_stall();
    s4_sel = 2'd3; s4_in_data = 32'h7700_0000;
    s4_in_valid = 4'b1000; s4_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (s4_in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready c=%0d got=%b want=0000", c, s4_in_ready);
      end
      tick();
      n_checks++;
      if ({s4_out_valid, s4_out_chan, s4_out_data} !== {1'b1, 2'd2, 8'hA5}) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d got=%b/%0d/%h want=1/2/a5",
                 c, s4_out_valid, s4_out_chan, s4_out_data);
      end
    end
    s4_out_ready = 1'b1;
    #1;
    n_checks++;
    if (s4_in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL drain_ready got=%b want=1000", s4_in_ready);
    end
    tick();
    n_checks++;
    if ({s4_out_valid, s4_out_chan, s4_out_data} !== {1'b1, 2'd3, 8'h77}) begin
      n_fail++;
      $display("FAIL drain_load got=%b/%0d/%h want=1/3/77",
               s4_out_valid, s4_out_chan, s4_out_data);
    end
    s4_sel = 2'd1; s4_in_valid = 4'b0000;
    #1;
    n_checks++;
    if (s4_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL ready_novalid got=%b want=0010", s4_in_ready);
    end
    tick();
    n_checks++;
    if ({s4_out_valid, s4_out_chan, s4_out_data} !== {1'b0, 2'd3, 8'h77}) begin
      n_fail++;
      $display("FAIL idle_hold got=%b/%0d/%h want=0/3/77",
               s4_out_valid, s4_out_chan, s4_out_data);
    end
  endtask

  task automatic test_sel_oob();
    s5_sel = 3'd4; s5_in_data = 40'h42_0000_0000;
    s5_in_valid = 5'b10000; s5_out_ready = 1'b0;
    #1;
    n_checks++;
    if (s5_in_ready !== 5'b10000) begin
      n_fail++;
      $display("FAIL oob_pre_ready got=%b want=10000", s5_in_ready);
    end
    tick();
    s5_sel = 3'd6; s5_in_valid = 5'b11111;
    tick();
    s5_out_ready = 1'b1;
    #1;
    n_checks++;
    if (s5_in_ready !== 5'b00000) begin
      n_fail++;
      $display("FAIL oob_ready got=%b want=00000", s5_in_ready);
    end
    n_checks++;
    if ({s5_out_valid, s5_out_data} !== {1'b1, 8'h42}) begin
      n_fail++;
      $display("FAIL oob_held got=%b/%h want=1/42", s5_out_valid, s5_out_data);
    end
    tick();
    n_checks++;
    if ({s5_out_valid, s5_out_chan, s5_out_data} !== {1'b0, 3'd4, 8'h42}) begin
      n_fail++;
      $display("FAIL oob_drain got=%b/%0d/%h want=0/4/42",
               s5_out_valid, s5_out_chan, s5_out_data);
    end
    s5_in_valid = '0;
  endtask

  task automatic test_rr_rotate();
    r4_in_data = 32'h4433_2211; r4_in_valid = 4'b1111;
    r4_out_ready = 1'b1;
    #1;
    n_checks++;
    if (r4_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first_ready got=%b want=0001", r4_in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({r4_out_valid, r4_out_chan, r4_out_data} !==
          {1'b1, 2'(k % 4), 8'(8'h11 * ((k % 4) + 1))}) begin
        n_fail++;
        $display("FAIL rr_rotate k=%0d got=%b/%0d/%h want=1/%0d",
                 k, r4_out_valid, r4_out_chan, r4_out_data, k % 4);
      end
    end
  endtask

  task automatic test_rr_wrap();
    r4_in_valid = 4'b1000;
    tick();
    n_checks++;
    if (r4_out_chan !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_ch3 got=%0d want=3", r4_out_chan);
    end
    r4_in_valid = 4'b1001;
    #1;
    n_checks++;
    if (r4_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ready got=%b want=0001", r4_in_ready);
    end
    tick();
    n_checks++;
    if (r4_out_chan !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_ch0 got=%0d want=0", r4_out_chan);
    end
    tick();
    n_checks++;
    if (r4_out_chan !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_back got=%0d want=3", r4_out_chan);
    end
  endtask

  task automatic test_reset_held();
    r4_in_data = 32'h0000_003C; r4_in_valid = 4'b0001;
    tick();
    r4_out_ready = 1'b0; r4_in_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({r4_out_valid, r4_out_data, r4_in_ready} !== {1'b1, 8'h3C, 4'b0}) begin
      n_fail++;
      $display("FAIL held_pre got=%b/%h/%b want=1/3c/0000",
               r4_out_valid, r4_out_data, r4_in_ready);
    end
    tick();
    n_checks++;
    if ({r4_out_valid, r4_out_data} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL held_rst got=%b/%h want=0/00", r4_out_valid, r4_out_data);
    end
    rst_n = 1'b1; r4_in_valid = 4'b1111; r4_out_ready = 1'b1;
    r4_in_data = 32'h4433_2211;
    #1;
    n_checks++;
    if (r4_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL restart_ready got=%b want=0001", r4_in_ready);
    end
    tick();
    n_checks++;
    if ({r4_out_valid, r4_out_chan, r4_out_data} !== {1'b1, 2'd0, 8'h11}) begin
      n_fail++;
      $display("FAIL restart_out got=%b/%0d/%h want=1/0/11",
               r4_out_valid, r4_out_chan, r4_out_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] er;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      s4_in_data = $urandom; s4_in_valid = 4'($urandom);
      s4_sel = 2'($urandom); s4_out_ready = 1'($urandom);
      s5_in_data = {8'($urandom), 32'($urandom)};
      s5_in_valid = 5'($urandom); s5_sel = 3'($urandom);
      s5_out_ready = 1'($urandom);
      r4_in_data = $urandom; r4_in_valid = 4'($urandom);
      r4_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_rdy(0, 4, m_v[0], s4_out_ready, int'(s4_sel), m_p[0],
                   {12'b0, s4_in_valid});
      n_checks++;
      if (s4_in_ready !== er[3:0]) begin
        n_fail++;
        $display("FAIL rnd_s4_ready c=%0d got=%b want=%b", c, s4_in_ready, er[3:0]);
      end
      er = exp_rdy(0, 5, m_v[1], s5_out_ready, int'(s5_sel), m_p[1],
                   {11'b0, s5_in_valid});
      n_checks++;
      if (s5_in_ready !== er[4:0]) begin
        n_fail++;
        $display("FAIL rnd_s5_ready c=%0d got=%b want=%b", c, s5_in_ready, er[4:0]);
      end
      er = exp_rdy(1, 4, m_v[2], r4_out_ready, 0, m_p[2],
                   {12'b0, r4_in_valid});
      n_checks++;
      if (r4_in_ready !== er[3:0]) begin
        n_fail++;
        $display("FAIL rnd_r4_ready c=%0d got=%b want=%b", c, r4_in_ready, er[3:0]);
      end
      tick();
      n_checks++;
      if ({s4_out_valid, s4_out_data, s4_out_chan} !==
          {m_v[0], m_d[0], m_c[0][1:0]}) begin
        n_fail++;
        $display("FAIL rnd_s4_out c=%0d got=%b/%h/%0d want=%b/%h/%0d", c,
                 s4_out_valid, s4_out_data, s4_out_chan, m_v[0], m_d[0], m_c[0]);
      end
      n_checks++;
      if ({s5_out_valid, s5_out_data, s5_out_chan} !==
          {m_v[1], m_d[1], m_c[1][2:0]}) begin
        n_fail++;
        $display("FAIL rnd_s5_out c=%0d got=%b/%h/%0d want=%b/%h/%0d", c,
                 s5_out_valid, s5_out_data, s5_out_chan, m_v[1], m_d[1], m_c[1]);
      end
      n_checks++;
      if ({r4_out_valid, r4_out_data, r4_out_chan} !==
          {m_v[2], m_d[2], m_c[2][1:0]}) begin
        n_fail++;
        $display("FAIL rnd_r4_out c=%0d got=%b/%h/%0d want=%b/%h/%0d", c,
                 r4_out_valid, r4_out_data, r4_out_chan, m_v[2], m_d[2], m_c[2]);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    s4_in_data = '0; s4_in_valid = '0; s4_sel = '0; s4_out_ready = 1'b0;
    s5_in_data = '0; s5_in_valid = '0; s5_sel = '0; s5_out_ready = 1'b0;
    r4_in_data = '0; r4_in_valid = '0; r4_sel = '0; r4_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sel_basic();
    test_sel_stall();
    test_sel_oob();
    test_rr_rotate();
    test_rr_wrap();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
